// File: rtl/timer_bank.sv
// timer_bank: one shared prescaler produces a base tick. N_CH independent
// channels count a programmable number of base ticks and emit a one-cycle
// expiry pulse, in one-shot or periodic mode. Every register runs on clk;
// there are no derived clocks.
module timer_bank #(
  parameter int CLK_HZ  = 100000000,
  parameter int TICK_HZ = 10,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [N_CH-1:0]         start,
  input  logic [N_CH-1:0]         cancel,
  input  logic [N_CH-1:0]         periodic,
  input  logic [N_CH*CNT_W-1:0]   load_val,
  output logic                    tick,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         expired
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // The divider must be an exact integer of at least 2.
  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_div_check
    $error("timer_bank: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [PRE_W-1:0] pre;

  state_t           state      [N_CH];
  state_t           state_nx   [N_CH];
  logic [CNT_W-1:0] cnt        [N_CH];
  logic [CNT_W-1:0] cnt_nx     [N_CH];
  logic [CNT_W-1:0] reload     [N_CH];
  logic [CNT_W-1:0] reload_nx  [N_CH];
  logic [N_CH-1:0]  mode;
  logic [N_CH-1:0]  mode_nx;
  logic [N_CH-1:0]  expired_nx;

  // Prescaler: counts enabled cycles and raises tick for one cycle every DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (clr) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      if (pre == PRE_MAX) begin
        pre  <= '0;
        tick <= 1'b1;
      end else begin
        pre  <= pre + PRE_ONE;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  // Channel next-state: clr, then cancel, then start, then tick decrement.
  // A decrement uses the registered tick alone, so a tick already issued
  // when en drops is still consumed and every expiry slips by exactly the
  // number of disabled cycles. Cancel on an idle channel does nothing but
  // still masks a simultaneous start.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_nx[i]   = state[i];
      cnt_nx[i]     = cnt[i];
      reload_nx[i]  = reload[i];
      mode_nx[i]    = mode[i];
      expired_nx[i] = 1'b0;

      if (clr) begin
        state_nx[i] = IDLE;
        cnt_nx[i]   = CNT_ZERO;
      end else if (cancel[i]) begin
        if (state[i] == RUN) begin
          state_nx[i] = IDLE;
          cnt_nx[i]   = CNT_ZERO;
        end
      end else if (start[i]) begin
        if (load_val[i*CNT_W +: CNT_W] != CNT_ZERO) begin
          state_nx[i]  = RUN;
          cnt_nx[i]    = load_val[i*CNT_W +: CNT_W];
          reload_nx[i] = load_val[i*CNT_W +: CNT_W];
          mode_nx[i]   = periodic[i];
        end else begin
          state_nx[i]   = IDLE;
          expired_nx[i] = 1'b1;
        end
      end else if (state[i] == RUN && tick) begin
        if (cnt[i] > CNT_ONE) begin
          cnt_nx[i] = cnt[i] - CNT_ONE;
        end else if (cnt[i] == CNT_ONE) begin
          expired_nx[i] = 1'b1;
          if (mode[i]) begin
            cnt_nx[i] = reload[i];
          end else begin
            state_nx[i] = IDLE;
            cnt_nx[i]   = CNT_ZERO;
          end
        end
      end
    end
  end

  // Channel state register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= CNT_ZERO;
        reload[i] <= CNT_ZERO;
      end
      mode    <= '0;
      expired <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state[i]  <= state_nx[i];
        cnt[i]    <= cnt_nx[i];
        reload[i] <= reload_nx[i];
      end
      mode    <= mode_nx;
      expired <= expired_nx;
    end
  end

  // busy mirrors the RUN state of each channel.
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_CH; i++) begin
      busy[i] = (state[i] == RUN);
    end
  end

endmodule
